// File: rtl/conv_window_fetch.sv
// Sliding 4x4 binary-patch fetcher: streams image rows from SRAM into four row
// registers and emits stride-2 windows over a valid/ready handshake.
module conv_window_fetch #(
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_address,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [15:0]       rd_data,
    output logic [15:0]       patch_data,
    output logic              patch_valid,
    input  logic              patch_ready,
    output logic [3:0]        patch_row,
    output logic [3:0]        patch_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_BAND = 4'(IMG_H - 4);
    localparam logic [3:0] LAST_COL  = 4'd12;

    state_t            state_q;
    logic [15:0]       rows_q [4];
    logic [3:0]        col_q;
    logic [3:0]        band_row_q;
    logic [1:0]        load_cnt_q;
    logic              cap_valid_q;
    logic [1:0]        cap_idx_q;
    logic [ADDR_W-1:0] base_q;
    logic              handshake;

    assign handshake   = (state_q == S_EMIT) && patch_ready;
    assign rd_en       = (state_q == S_LOAD);
    // Row being fetched: band_row + load_cnt; later bands start load_cnt at 2.
    assign rd_address  = base_q + ADDR_W'(band_row_q) + ADDR_W'(load_cnt_q);
    assign patch_valid = (state_q == S_EMIT);
    assign patch_row   = band_row_q;
    assign patch_col   = col_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        patch_data = '0;
        if (state_q == S_EMIT) begin
            for (int k = 0; k < 4; k++) begin
                patch_data[4*k +: 4] = 4'(rows_q[k] >> col_q);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            band_row_q  <= '0;
            load_cnt_q  <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            base_q      <= '0;
            // NOTE: the row registers are a tiny flop array, not RAM, so they
            // are cleared on reset like any other state.
            for (int k = 0; k < 4; k++) begin
                rows_q[k] <= '0;
            end
        end else begin
            cap_valid_q <= 1'b0;
            // SRAM data arrives one cycle after its read strobe.
            if (cap_valid_q) begin
                rows_q[cap_idx_q] <= rd_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_address;
                        band_row_q <= '0;
                        col_q      <= '0;
                        load_cnt_q <= '0;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cap_valid_q <= 1'b1;
                    cap_idx_q   <= load_cnt_q;
                    load_cnt_q  <= load_cnt_q + 2'd1;
                    if (load_cnt_q == 2'd3) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (handshake) begin
                        if (col_q != LAST_COL) begin
                            col_q <= col_q + 4'd2;
                        end else if (band_row_q == LAST_BAND) begin
                            state_q <= S_DONE;
                        end else begin
                            // Slide the band down two rows; only two new rows are fetched.
                            rows_q[0]  <= rows_q[2];
                            rows_q[1]  <= rows_q[3];
                            band_row_q <= band_row_q + 4'd2;
                            col_q      <= '0;
                            load_cnt_q <= 2'd2;
                            state_q    <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch: a golden 4x4 extractor queues expected
// patches per frame and a negedge monitor pops and compares on each handshake.
module tb_conv_window_fetch;

    localparam int IMG_H  = 16;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_address;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_address;
    logic [15:0]       rd_data;
    logic [15:0]       patch_data;
    logic              patch_valid;
    logic              patch_ready;
    logic [3:0]        patch_row;
    logic [3:0]        patch_col;
    logic              busy;
    logic              done;

    conv_window_fetch #(
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_address (base_address),
        .rd_en        (rd_en),
        .rd_address   (rd_address),
        .rd_data      (rd_data),
        .patch_data   (patch_data),
        .patch_valid  (patch_valid),
        .patch_ready  (patch_ready),
        .patch_row    (patch_row),
        .patch_col    (patch_col),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  row;
        logic [3:0]  col;
    } patch_t;

    patch_t            sb[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [15:0]       img [IMG_H];
    logic [15:0]       mem [1 << ADDR_W];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    int          first_rd = -1;
    int          first_pv = -1;
    logic [15:0] first_patch = '0;
    int          done_cnt = 0;
    int          pop_cnt  = 0;
    int          rdy_mode = 0;
    bit          bp_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] golden(input int br, input int c);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                p[4*k + j] = img[br + k][c + j];
            end
        end
        return p;
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_address];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: logs reads and frame milestones, checks every accepted patch.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                addr_log.push_back(rd_address);
                if (first_rd < 0) first_rd = cyc - t0;
            end
            if (patch_valid && first_pv < 0) begin
                first_pv    = cyc - t0;
                first_patch = patch_data;
            end
            if (done) done_cnt++;
            if (patch_valid && patch_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_patch: got row=%0d col=%0d data=%h expected no patch",
                             patch_row, patch_col, patch_data);
                end else begin
                    patch_t e;
                    e = sb.pop_front();
                    check($sformatf("patch_%0d", pop_cnt),
                          {8'h00, patch_data, patch_row, patch_col},
                          {8'h00, e.data, e.row, e.col});
                    pop_cnt++;
                end
            end
        end
    end

    // Consumer: ready policy per mode; mode 2 stalls 5 cycles at patch (2,4).
    initial begin
        patch_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                patch_ready = 1'($urandom_range(0, 1));
            end else if (rdy_mode == 2 && !bp_done && patch_valid && patch_row == 4'd2 && patch_col == 4'd4) begin
                bp_done     = 1'b1;
                patch_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("stall_%0d", i),
                          {6'h00, rd_en, patch_valid, patch_row, patch_col, patch_data},
                          {6'h00, 1'b0, 1'b1, 4'd2, 4'd4, golden(2, 4)});
                    if (i < 4) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end else begin
                patch_ready = 1'b1;
            end
        end
    end

    task automatic run_frame(input logic [ADDR_W-1:0] base, input int mode, input int abort_at,
                             input bit timing, input bit spurious);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] exp_addr[$];
        int                done0;
        int                pops0;
        bit                got_done;

        for (int r = 0; r < IMG_H; r++) begin
            a      = base + ADDR_W'(r);
            mem[a] = img[r];
        end
        for (int br = 0; br <= IMG_H - 4; br += 2) begin
            for (int c = 0; c <= 12; c += 2) begin
                sb.push_back('{golden(br, c), 4'(br), 4'(c)});
            end
        end
        for (int i = 0; i < 4; i++) exp_addr.push_back(base + ADDR_W'(i));
        for (int b = 1; b <= (IMG_H - 4) / 2; b++) begin
            exp_addr.push_back(base + ADDR_W'(2 * b + 2));
            exp_addr.push_back(base + ADDR_W'(2 * b + 3));
        end

        rdy_mode = mode;
        bp_done  = 1'b0;
        addr_log.delete();
        done0    = done_cnt;
        pops0    = pop_cnt;
        got_done = 1'b0;

        @(posedge clk);
        #1;
        first_rd     = -1;
        first_pv     = -1;
        base_address = base;
        start        = 1'b1;
        t0           = cyc;

        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk);
            #1;
            start        = 1'b0;
            base_address = 12'h555;
            if (abort_at >= 0 && cyc - t0 == abort_at) begin
                check("abort_in_load", {31'h0, rd_en}, 32'h1);
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                check("abort_outputs_zero",
                      {rd_en, rd_address, patch_data, patch_valid, patch_row, patch_col, busy, done}, '0);
                repeat (80) @(posedge clk);
                #1;
                check("abort_no_done", done_cnt, done0);
                check("abort_idle", {31'h0, busy}, 32'h0);
                sb.delete();
                rdy_mode = 0;
                return;
            end
            if (spurious && cyc - t0 == 20) start = 1'b1;
            if (done) begin
                got_done = 1'b1;
                if (spurious) start = 1'b1;
                if (timing) check("done_cycle", cyc - t0, 73);
            end
        end
        if (!got_done) check("done_timeout", 32'h0, 32'h1);

        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_after_done", {30'h0, busy, done}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("stays_idle", {31'h0, busy}, 32'h0);
        if (timing) begin
            check("first_rd_cycle", first_rd, 1);
            check("first_valid_cycle", first_pv, 6);
        end
        check("patch_count", pop_cnt - pops0, 49);
        check("sb_empty", sb.size(), 0);
        check("addr_count", addr_log.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
            check($sformatf("rd_address_%0d", i), 32'(addr_log[i]), 32'(exp_addr[i]));
        end
        sb.delete();
        rdy_mode = 0;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_address = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {rd_en, rd_address, patch_data, patch_valid, patch_row, patch_col, busy, done}, '0);
        reset = 1'b0;

        // Identity image: diagonal patch, full timeline.
        for (int r = 0; r < IMG_H; r++) img[r] = 16'h0001 << (r % 16);
        run_frame(12'h000, 0, -1, 1'b1, 1'b0);
        check("identity_patch00", {16'h0, first_patch}, 32'h0000_8421);

        // All-ones image.
        for (int r = 0; r < IMG_H; r++) img[r] = 16'hFFFF;
        run_frame(12'h100, 0, -1, 1'b1, 1'b0);

        // Random image, random backpressure.
        for (int r = 0; r < IMG_H; r++) img[r] = 16'($urandom);
        run_frame(12'h200, 1, -1, 1'b0, 1'b0);

        // Directed 5-cycle stall at patch (2,4).
        for (int r = 0; r < IMG_H; r++) img[r] = 16'($urandom);
        run_frame(12'h300, 2, -1, 1'b0, 1'b0);
        check("stall_seen", {31'h0, bp_done}, 32'h1);

        // Reset during the second band's LOAD, then a fresh frame.
        for (int r = 0; r < IMG_H; r++) img[r] = 16'($urandom);
        run_frame(12'h400, 0, 13, 1'b0, 1'b0);
        run_frame(12'h400, 0, -1, 1'b1, 1'b0);

        // Address wrap with start pulses while busy and in the done cycle.
        for (int r = 0; r < IMG_H; r++) img[r] = 16'($urandom);
        run_frame(12'hFFE, 0, -1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
